// File: rtl/red_dec_ctrl.sv
// red_dec_ctrl: frame sequencer between the last conv layer and the reduction/decision back end
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_column   upstream column stream
//   red_valid/red_start/red_last  registered column beat to the reduction datapath
//   red_column                    registered column, held between beats
//   dec_valid/dec_max/dec_index   decision result pulse
//   res_valid/res_ready           held result handshake
//   res_max/res_index             captured result
//   frame_cnt                     consumed frames, wraps
//   err_timeout/err_spurious      sticky watchdog and unexpected-decision flags
module red_dec_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int N_MATS = 10,
    parameter int COLS_PER_FRAME = 12,
    parameter int TIMEOUT = 64,
    localparam int IW = $clog2(N_MATS)
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic [1:0][N_MATS-1:0][DATA_WIDTH-1:0] in_column,
    output logic red_valid,
    output logic red_start,
    output logic red_last,
    output logic [1:0][N_MATS-1:0][DATA_WIDTH-1:0] red_column,
    input  logic dec_valid,
    input  logic [DATA_WIDTH-1:0] dec_max,
    input  logic [IW-1:0] dec_index,
    output logic res_valid,
    input  logic res_ready,
    output logic [DATA_WIDTH-1:0] res_max,
    output logic [IW-1:0] res_index,
    output logic [15:0] frame_cnt,
    output logic err_timeout,
    output logic err_spurious
);
    localparam int CW = $clog2(COLS_PER_FRAME + 1);
    localparam int WW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, FEED, WAIT_DEC, HOLD} state_t;
    state_t state;
    logic [CW-1:0] col_cnt, col_nxt;
    logic [WW-1:0] wd;
    logic acc, last;
    assign in_ready = state == IDLE || state == FEED;
    assign acc = in_valid && in_ready;
    // count this beat would reach: restart at 1 on the first beat of a frame
    assign col_nxt = state == IDLE ? CW'(1) : col_cnt + CW'(1);
    assign last = col_nxt == CW'(COLS_PER_FRAME);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            col_cnt <= '0;
            wd <= '0;
            frame_cnt <= '0;
            red_valid <= 1'b0;
            red_start <= 1'b0;
            red_last <= 1'b0;
            red_column <= '0;
            res_valid <= 1'b0;
            res_max <= '0;
            res_index <= '0;
            err_timeout <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            red_valid <= acc;
            red_start <= acc && state == IDLE;
            red_last <= acc && last;
            if (acc) begin
                red_column <= in_column;
                col_cnt <= col_nxt;
                wd <= '0;
                state <= last ? WAIT_DEC : FEED;
            end
            if (dec_valid && state != WAIT_DEC) err_spurious <= 1'b1;
            // a decision arriving on the expiry cycle takes priority over the watchdog
            if (state == WAIT_DEC) begin
                if (dec_valid) begin
                    res_max <= dec_max;
                    res_index <= dec_index;
                    res_valid <= 1'b1;
                    state <= HOLD;
                end else if (wd == WW'(TIMEOUT - 1)) begin
                    err_timeout <= 1'b1;
                    state <= IDLE;
                end else begin
                    wd <= wd + WW'(1);
                end
            end
            if (state == HOLD && res_ready) begin
                res_valid <= 1'b0;
                frame_cnt <= frame_cnt + 16'd1;
                state <= IDLE;
            end
        end
    end
endmodule
